// File: rtl/debounce_sync.sv
// Input synchronizer plus debounce FSM with registered level output and edge pulses.
// Define DEBOUNCE_EDGE_EN to build the rise/fall pulse registers; otherwise rise/fall are tied 0.
module debounce_sync #(
    parameter int CNT_MAX     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic rst,
    input  logic din,
    output logic Q,
    output logic rise,
    output logic fall,
    output logic busy
);

    // state     | meaning
    // ST_LOW    | Q=0 settled, waiting for din_s to go high
    // ST_WAIT_H | din_s high, counting stable samples before Q rises
    // ST_HIGH   | Q=1 settled, waiting for din_s to go low
    // ST_WAIT_L | din_s low, counting stable samples before Q falls
    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_WAIT_H = 2'd1,
        ST_HIGH   = 2'd2,
        ST_WAIT_L = 2'd3
    } state_t;

    localparam int              CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   din_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_q, q_d;

    always_ff @(posedge Clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign din_s = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
`ifdef DEBOUNCE_EDGE_EN
        rise_d  = 1'b0;
        fall_d  = 1'b0;
`endif
        case (state_q)
            ST_LOW: begin
                if (din_s) begin
                    state_d = ST_WAIT_H;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_H: begin
                if (!din_s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    q_d     = 1'b1;
`ifdef DEBOUNCE_EDGE_EN
                    rise_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!din_s) begin
                    state_d = ST_WAIT_L;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_L: begin
                if (din_s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    q_d     = 1'b0;
`ifdef DEBOUNCE_EDGE_EN
                    fall_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            q_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    always_ff @(posedge Clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

    assign Q    = q_q;
    assign busy = (state_q == ST_WAIT_H) || (state_q == ST_WAIT_L);

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: run-length model of the debounce rule checked every cycle,
// two instances (CNT_MAX=4 and CNT_MAX=1), plus literal timing checks.
module tb_debounce_sync;

    localparam int SS = 2;
    localparam int CM [2] = '{4, 1};
`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic Clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic q0, r0, f0, b0;
    logic q1, r1, f1, b1;

    int tests  = 0;
    int failed = 0;
    bit started = 1'b0;

    always #5 Clk = ~Clk;

    debounce_sync #(.CNT_MAX(4), .SYNC_STAGES(SS)) dut0 (
        .Clk(Clk), .rst(rst), .din(din), .Q(q0), .rise(r0), .fall(f0), .busy(b0)
    );

    debounce_sync #(.CNT_MAX(1), .SYNC_STAGES(SS)) dut1 (
        .Clk(Clk), .rst(rst), .din(din), .Q(q1), .rise(r1), .fall(f1), .busy(b1)
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: Q flips once the synchronized input has disagreed with Q for CNT_MAX+1
    // consecutive samples; busy while a disagreement run is in progress.
    logic [SS-1:0] sh_m [2];
    int            run_m [2];
    logic          q_m [2];
    logic          r_m [2];
    logic          f_m [2];
    logic          b_m [2];
    logic          ds_m;

    always @(posedge Clk) begin
        started = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                sh_m[i]  = '0;
                run_m[i] = 0;
                q_m[i]   = 1'b0;
                r_m[i]   = 1'b0;
                f_m[i]   = 1'b0;
            end else begin
                ds_m     = sh_m[i][SS-1];
                sh_m[i]  = {sh_m[i][SS-2:0], din};
                r_m[i]   = 1'b0;
                f_m[i]   = 1'b0;
                if (ds_m != q_m[i]) begin
                    run_m[i]++;
                    if (run_m[i] == CM[i] + 1) begin
                        q_m[i]   = ds_m;
                        r_m[i]   = ds_m;
                        f_m[i]   = ~ds_m;
                        run_m[i] = 0;
                    end
                end else begin
                    run_m[i] = 0;
                end
            end
            b_m[i] = (run_m[i] != 0);
        end
    end

    always @(negedge Clk) begin
        if (started) begin
            chk("q0",    q0, q_m[0]);
            chk("busy0", b0, b_m[0]);
            chk("rise0", r0, EDGE_EN & r_m[0]);
            chk("fall0", f0, EDGE_EN & f_m[0]);
            chk("q1",    q1, q_m[1]);
            chk("busy1", b1, b_m[1]);
            chk("rise1", r1, EDGE_EN & r_m[1]);
            chk("fall1", f1, EDGE_EN & f_m[1]);
            chk("no_rise_fall_both0", r0 & f0, 1'b0);
        end
    end

    logic [31:0] pat;

    initial begin
        rst = 1'b1;
        din = 1'b0;
        repeat (2) @(negedge Clk);
        chk("reset_q0", q0, 1'b0);
        chk("reset_busy0", b0, 1'b0);
        chk("reset_rise0", r0, 1'b0);

        // clean 0->1, Q must rise on the 7th edge (4th for CNT_MAX=1)
        rst = 1'b0;
        din = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rise_busy0_e2", b0, 1'b0);
        @(negedge Clk);
        chk("rise_busy0_e3", b0, 1'b1);
        chk("cnt1_q_e3", q1, 1'b0);
        @(negedge Clk);
        chk("cnt1_q_e4", q1, 1'b1);
        chk("cnt1_rise_e4", r1, EDGE_EN);
        repeat (2) @(negedge Clk);
        chk("rise_q0_e6", q0, 1'b0);
        chk("rise_busy0_e6", b0, 1'b1);
        @(negedge Clk);
        chk("rise_q0_e7", q0, 1'b1);
        chk("rise_pulse0_e7", r0, EDGE_EN);
        chk("rise_busy0_e7", b0, 1'b0);
        @(negedge Clk);
        chk("rise_pulse0_e8", r0, 1'b0);
        chk("rise_q0_e8", q0, 1'b1);
        repeat (4) @(negedge Clk);

        // clean 1->0
        din = 1'b0;
        repeat (6) @(negedge Clk);
        chk("fall_q0_e6", q0, 1'b1);
        @(negedge Clk);
        chk("fall_q0_e7", q0, 1'b0);
        chk("fall_pulse0_e7", f0, EDGE_EN);
        chk("fall_norise0_e7", r0, 1'b0);
        @(negedge Clk);
        chk("fall_pulse0_e8", f0, 1'b0);
        repeat (4) @(negedge Clk);

        // bounce: high for 3 cycles only
        din = 1'b1;
        repeat (3) @(negedge Clk);
        din = 1'b0;
        repeat (2) @(negedge Clk);
        chk("bounce_busy0_e5", b0, 1'b1);
        chk("bounce_q0_e5", q0, 1'b0);
        @(negedge Clk);
        chk("bounce_busy0_e6", b0, 1'b0);
        chk("bounce_q0_e6", q0, 1'b0);
        chk("bounce_rise0_e6", r0, 1'b0);
        repeat (6) @(negedge Clk);

        // reset in the third cycle of WAIT_H, din held high through release
        din = 1'b1;
        repeat (5) @(negedge Clk);
        chk("rstwait_busy0", b0, 1'b1);
        rst = 1'b1;
        @(negedge Clk);
        chk("rstwait_q0", q0, 1'b0);
        chk("rstwait_busy0_rst", b0, 1'b0);
        chk("rstwait_rise0_rst", r0, 1'b0);
        chk("rstwait_fall1_rst", f1, 1'b0);
        rst = 1'b0;
        @(negedge Clk);
        chk("rstwait_rise0_after", r0, 1'b0);
        chk("rstwait_fall1_after", f1, 1'b0);
        repeat (5) @(negedge Clk);
        chk("rstwait_q0_e6", q0, 1'b0);
        @(negedge Clk);
        chk("rstwait_q0_e7", q0, 1'b1);
        chk("rstwait_rise0_e7", r0, EDGE_EN);
        repeat (3) @(negedge Clk);

        // reset while settled high: no fall pulse
        rst = 1'b1;
        @(negedge Clk);
        chk("rsthigh_q0", q0, 1'b0);
        chk("rsthigh_fall0", f0, 1'b0);
        rst = 1'b0;
        @(negedge Clk);
        chk("rsthigh_fall0_after", f0, 1'b0);
        repeat (10) @(negedge Clk);

        // glitch train checked by the model only
        pat = 32'b1110_1101_1111_0000_0001_1000_0111_1111;
        for (int i = 31; i >= 0; i--) begin
            din = pat[i];
            @(negedge Clk);
        end
        din = 1'b0;
        repeat (12) @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 The block SHALL have parameter CNT_MAX, default 4, meaning the number of consecutive stable synchronized samples required after a level change (legal range 1..65535).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer flop depth (legal range 2..4).
REQ-003 Port Clk  input  1  the single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port din  input  1  raw asynchronous/bouncing input level.
REQ-006 Port Q  output  1  debounced, registered level; drives the D input of the downstream D_FF stage.
REQ-007 Port rise  output  1  one-cycle pulse when Q goes 0->1.
REQ-008 Port fall  output  1  one-cycle pulse when Q goes 1->0.
REQ-009 Port busy  output  1  high while a level change is being qualified; decoded from state only.

Function
REQ-010 din SHALL pass through SYNC_STAGES flops in series; the last stage output is din_s, and only din_s SHALL feed any other logic.
REQ-011 FSM states SHALL be ST_LOW, ST_WAIT_H, ST_HIGH, ST_WAIT_L; counter cnt SHALL be max(1,$clog2(CNT_MAX)) bits, unsigned, never wrapping.
REQ-012 ST_LOW: din_s=1 -> ST_WAIT_H with cnt<=0; else stay.
REQ-013 ST_WAIT_H: din_s=0 -> ST_LOW with cnt<=0 (bounce abort, no pulse); din_s=1 and cnt==CNT_MAX-1 -> ST_HIGH, Q<=1, rise<=1; otherwise din_s=1 -> cnt<=cnt+1.
REQ-014 ST_HIGH and ST_WAIT_L SHALL mirror REQ-012/013 with polarity inverted, setting Q<=0 and fall<=1 on entry to ST_LOW.
REQ-015 Latency: a din change held stable SHALL update Q on exactly the (SYNC_STAGES+CNT_MAX+1)th rising Clk edge after the edge that first samples it (7 edges at defaults).
REQ-016 Any din pulse or glitch shorter than CNT_MAX+1 synchronized cycles SHALL leave Q, rise and fall unchanged.
REQ-017 rise and fall SHALL be registered, high for exactly one cycle, coincident with the cycle Q changes, and never high simultaneously.
REQ-018 busy SHALL be 1 exactly in ST_WAIT_H and ST_WAIT_L, 0 otherwise.
REQ-019 With CNT_MAX=1 a WAIT state SHALL last exactly one cycle when din_s stays stable.

Reset
REQ-020 rst SHALL be sampled only on rising Clk and take priority over all other logic.
REQ-021 On reset: all synchronizer flops 0, state ST_LOW, cnt 0, Q 0, rise 0, fall 0, busy 0.
REQ-022 Reset asserted mid-qualification (either WAIT state) or in ST_HIGH SHALL abort without emitting rise or fall in the reset cycle or the cycle after.
REQ-023 din held high through reset release SHALL be treated as a fresh 0->1 change, producing Q=1 and one rise pulse with REQ-015 latency counted from the first post-reset edge.

Configuration
REQ-024 Macro DEBOUNCE_EDGE_EN SHALL, when defined, compile in the rise/fall pulse registers per REQ-007/008/017.
REQ-025 Without DEBOUNCE_EDGE_EN, rise and fall SHALL be tied constant 0 with no pulse registers present; Q, busy and all timing SHALL be identical.

Verification
REQ-026 Defaults, rst=1 for 2 cycles then 0, din 0->1 held -> Q=1 on 7th edge after first sample, rise=1 for that one cycle only, busy=1 for the 4 cycles before.
REQ-027 din high 3 cycles then low (bounce) -> Q stays 0, rise never asserted, state returns to ST_LOW, busy drops.
REQ-028 Q=1 steady, din 1->0 held -> Q=0 after 7 edges, fall=1 for one cycle, rise stays 0.
REQ-029 din high, rst=1 asserted on 3rd cycle of ST_WAIT_H for 1 cycle -> Q=0, no pulse, din still high -> Q=1 7 edges after reset release.
REQ-030 CNT_MAX=1, SYNC_STAGES=2, din 0->1 held -> Q=1 on 4th edge.
REQ-031 Build without DEBOUNCE_EDGE_EN, rerun REQ-026 stimulus -> identical Q/busy waveform, rise=fall=0 throughout.
